// File: rtl/sram_c_arbiter.sv
// Single-port C-buffer SRAM owner: arbitrates array writeback against host reads
// (with a read starvation guard) and runs a sequential zero-fill clear engine.
module sram_c_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic [0:0]        dbg_state
);

  // Handshake: a request transfers in the cycle where valid && ready; ready is a
  // combinational grant that never depends on anything but current-cycle inputs
  // and registered state, and at most one ready is high per cycle.

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [0:0]        ST_IDLE    = 1'b0;
  localparam logic [0:0]        ST_CLEAR   = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              clr_done_q, clr_done_d;
  logic              rd_rvalid_q, rd_rvalid_d;
  logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;
  logic              rd_win;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    starve_d     = starve_q;
    clr_done_d   = 1'b0;
    rd_rvalid_d  = 1'b0;
    rdata_hold_d = rd_rvalid_q ? sram_dout : rdata_hold_q;
    rd_win       = 1'b0;
    wb_ready     = 1'b0;
    rd_ready     = 1'b0;
    sram_ce      = 1'b0;
    sram_we      = 1'b0;
    sram_addr    = '0;
    sram_din     = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          // A starved read overrides the default writeback priority.
          rd_win   = rd_valid && (!wb_valid || (starve_q == STARVE_LIM));
          rd_ready = rd_win;
          wb_ready = wb_valid && !rd_win;
          if (wb_ready) begin
            sram_ce   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = wb_addr;
            sram_din  = wb_data;
          end else if (rd_ready) begin
            sram_ce   = 1'b1;
            sram_addr = rd_addr;
          end
          if (!rd_valid || rd_ready) begin
            starve_d = '0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + SW'(1);
          end
          rd_rvalid_d = rd_ready;
          if (clr_start) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
          end
        end
        default: begin
          sram_ce   = 1'b1;
          sram_we   = 1'b1;
          sram_addr = clr_cnt_q;
          if (clr_cnt_q == LAST_ADDR) begin
            state_d    = ST_IDLE;
            clr_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      starve_q     <= '0;
      clr_done_q   <= 1'b0;
      rd_rvalid_q  <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      starve_q     <= starve_d;
      clr_done_q   <= clr_done_d;
      rd_rvalid_q  <= rd_rvalid_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  // Reset takes effect on status outputs at once so an aborted clear never lingers.
  assign clr_busy  = (state_q == ST_CLEAR) && !rst;
  assign clr_done  = clr_done_q && !rst;
  assign rd_rvalid = rd_rvalid_q && !rst;
  assign rd_rdata  = rd_rvalid_q ? sram_dout : rdata_hold_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_c_arbiter.sv
// Randomized and directed bench for sram_c_arbiter against a cycle-level
// reference model of the arbitration rules, with a behavioural SRAM attached.
module tb_sram_c_arbiter;

  localparam int DEPTH = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_start;
  logic       clr_busy;
  logic       clr_done;
  logic       wb_valid;
  logic       wb_ready;
  logic [9:0] wb_addr;
  logic [7:0] wb_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [9:0] rd_addr;
  logic       rd_rvalid;
  logic [7:0] rd_rdata;
  logic       sram_ce;
  logic       sram_we;
  logic [9:0] sram_addr;
  logic [7:0] sram_din;
  logic [7:0] sram_dout;
  logic [0:0] dbg_state;

  sram_c_arbiter dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_rvalid(rd_rvalid),
    .rd_rdata(rd_rdata), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM with registered read data that holds when not enabled.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout <= mem[sram_addr];
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] exp_q [$];
  int  m_busy, m_clr_addr, m_starve, m_done, m_rvalid, m_have_last;
  int  m_last;
  int  n_vec, n_err;
  int  busy_cnt, done_cnt;
  logic       obs_rd_ready, obs_rvalid;
  logic [7:0] obs_rdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idle();
    clr_start = 1'b0;
    wb_valid  = 1'b0;
    rd_valid  = 1'b0;
  endtask

  // One clock: inputs are already applied; compare at negedge, advance the model.
  task automatic step();
    int rd_wins, wb_wins, e_ce, e_we, e_addr, e_din, next_done, next_rvalid;
    logic [7:0] e_data;
    @(negedge clk);
    obs_rd_ready = rd_ready;
    obs_rvalid   = rd_rvalid;
    obs_rdata    = rd_rdata;
    if (clr_busy) busy_cnt++;
    if (clr_done) done_cnt++;
    if (rst) begin
      check_eq("rst_wb_ready", 32'(wb_ready), 0);
      check_eq("rst_rd_ready", 32'(rd_ready), 0);
      check_eq("rst_ce", 32'(sram_ce), 0);
      check_eq("rst_we", 32'(sram_we), 0);
      check_eq("rst_busy", 32'(clr_busy), 0);
      check_eq("rst_done", 32'(clr_done), 0);
      check_eq("rst_rvalid", 32'(rd_rvalid), 0);
      m_busy = 0; m_clr_addr = 0; m_starve = 0; m_done = 0; m_rvalid = 0;
      m_have_last = 0;
      exp_q.delete();
    end else begin
      rd_wins = 0; wb_wins = 0; e_ce = 0; e_we = 0; e_addr = 0; e_din = 0;
      if (m_busy != 0) begin
        e_ce = 1; e_we = 1; e_addr = m_clr_addr; e_din = 0;
      end else begin
        rd_wins = (rd_valid && (!wb_valid || m_starve >= 4)) ? 1 : 0;
        wb_wins = (wb_valid && rd_wins == 0) ? 1 : 0;
        if (wb_wins != 0) begin
          e_ce = 1; e_we = 1; e_addr = int'(wb_addr); e_din = int'(wb_data);
        end else if (rd_wins != 0) begin
          e_ce = 1; e_addr = int'(rd_addr);
        end
      end
      check_eq("wb_ready", 32'(wb_ready), wb_wins);
      check_eq("rd_ready", 32'(rd_ready), rd_wins);
      check_eq("sram_ce", 32'(sram_ce), e_ce);
      check_eq("sram_we", 32'(sram_we), e_we);
      if (e_ce != 0) check_eq("sram_addr", 32'(sram_addr), e_addr);
      if (e_we != 0) check_eq("sram_din", 32'(sram_din), e_din);
      check_eq("clr_busy", 32'(clr_busy), m_busy);
      check_eq("clr_done", 32'(clr_done), m_done);
      check_eq("rd_rvalid", 32'(rd_rvalid), m_rvalid);
      if (m_rvalid != 0) begin
        if (exp_q.size() == 0) begin
          check_eq("rdata_queue_empty", 1, 0);
        end else begin
          e_data = exp_q.pop_front();
          check_eq("rd_rdata", 32'(rd_rdata), 32'(e_data));
          m_last = int'(e_data);
          m_have_last = 1;
        end
      end else if (m_have_last != 0) begin
        check_eq("rd_rdata_hold", 32'(rd_rdata), m_last);
      end
      next_done = 0; next_rvalid = 0;
      if (m_busy != 0) begin
        ref_mem[m_clr_addr] = 8'h00;
        if (m_clr_addr == DEPTH - 1) begin
          m_busy = 0; next_done = 1;
        end else begin
          m_clr_addr++;
        end
      end else begin
        if (wb_wins != 0) ref_mem[wb_addr] = wb_data;
        if (rd_wins != 0) exp_q.push_back(ref_mem[rd_addr]);
        if (rd_wins != 0 || !rd_valid) m_starve = 0;
        else if (m_starve < 4) m_starve++;
        if (clr_start) begin
          m_busy = 1; m_clr_addr = 0;
        end
        next_rvalid = rd_wins;
      end
      m_done = next_done;
      m_rvalid = next_rvalid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    step();
    set_idle();
  endtask

  // Read issued alone; response lands in obs_* during the second step.
  task automatic do_read(input logic [9:0] a);
    rd_valid = 1'b1; rd_addr = a;
    step();
    set_idle();
    step();
  endtask

  // Runs the clear to completion with ignored request noise and busy clr_start pulses.
  task automatic finish_clear();
    int budget;
    budget = 0;
    while (m_busy != 0 && budget < 2000) begin
      wb_valid  = 1'($urandom_range(0, 1));
      rd_valid  = 1'($urandom_range(0, 1));
      wb_addr   = 10'($urandom_range(0, 1023));
      wb_data   = 8'($urandom_range(1, 255));
      rd_addr   = 10'($urandom_range(0, 1023));
      clr_start = ($urandom_range(0, 99) == 0);
      step();
      budget++;
    end
    set_idle();
    if (budget >= 2000) check_eq("clear_timeout", 1, 0);
    step();
  endtask

  initial begin
    logic [9:0] mask;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    sram_dout = 8'h00;
    n_vec = 0; n_err = 0; busy_cnt = 0; done_cnt = 0;
    m_busy = 0; m_clr_addr = 0; m_starve = 0; m_done = 0; m_rvalid = 0;
    m_have_last = 0; m_last = 0;
    rst = 1'b1;
    set_idle();
    wb_addr = '0; wb_data = '0; rd_addr = '0;
    @(posedge clk);
    #1;
    // Reset with requests pending: no grants, no SRAM activity.
    wb_valid = 1'b1; rd_valid = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    set_idle();
    step();

    // Write then read back; write at N, read at N+1.
    do_write(10'h123, 8'h5A);
    step();
    do_read(10'h123);
    check_eq("t1_rvalid", 32'(obs_rvalid), 1);
    check_eq("t1_rdata", 32'(obs_rdata), 32'h5A);
    do_write(10'h124, 8'hC3);
    do_read(10'h124);
    check_eq("t1_back2back", 32'(obs_rdata), 32'hC3);

    // Both requesters held: rd granted only on cycles 5 and 10.
    step();
    mask = '0;
    wb_valid = 1'b1; rd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wb_addr = 10'($urandom_range(0, 31));
      wb_data = 8'($urandom_range(0, 255));
      rd_addr = 10'($urandom_range(0, 31));
      step();
      mask[i] = obs_rd_ready;
    end
    set_idle();
    check_eq("t2_grant_pattern", 32'(mask), 32'h210);
    step(); step();

    // Fill corners, clear the whole buffer, read back zeros.
    do_write(10'h3FF, 8'hFF);
    do_write(10'h000, 8'hFF);
    busy_cnt = 0; done_cnt = 0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    finish_clear();
    check_eq("t3_busy_len", busy_cnt, 1024);
    check_eq("t3_done_cnt", done_cnt, 1);
    do_read(10'h000);
    check_eq("t3_rd0", 32'(obs_rdata), 0);
    do_read(10'h3FF);
    check_eq("t3_rd3ff", 32'(obs_rdata), 0);

    // clr_start with a read in the same cycle: read still completes.
    do_write(10'h010, 8'hAB);
    clr_start = 1'b1; rd_valid = 1'b1; rd_addr = 10'h010;
    step();
    set_idle();
    step();
    check_eq("t4_rvalid", 32'(obs_rvalid), 1);
    check_eq("t4_rdata", 32'(obs_rdata), 32'hAB);
    finish_clear();

    // Reset mid-clear at address 500: abort, no done, later words untouched.
    do_write(10'd600, 8'hFF);
    done_cnt = 0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 600 && m_clr_addr < 500; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step();
    check_eq("t5_no_done", done_cnt, 0);
    check_eq("t5_busy", 32'(clr_busy), 0);
    do_read(10'd600);
    check_eq("t5_keep600", 32'(obs_rdata), 32'hFF);
    busy_cnt = 0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    finish_clear();
    check_eq("t5_restart_len", busy_cnt, 1024);

    // Idle cycles: no SRAM activity, read data held.
    do_write(10'h055, 8'h3C);
    do_read(10'h055);
    repeat (5) step();
    check_eq("t6_hold", 32'(rd_rdata), 32'h3C);

    // Randomized traffic on a small address window, rare clears.
    for (int i = 0; i < 500; i++) begin
      wb_valid  = ($urandom_range(0, 99) < 50);
      rd_valid  = ($urandom_range(0, 99) < 60);
      wb_addr   = 10'($urandom_range(0, 15));
      wb_data   = 8'($urandom_range(0, 255));
      rd_addr   = 10'($urandom_range(0, 15));
      clr_start = ($urandom_range(0, 399) == 0);
      step();
      if (m_busy != 0) finish_clear();
    end
    set_idle();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
